// File: rtl/ppe_conv_sync.sv
// Partial-sum PE: loads a FILTER_W-tap weight row, then convolves binary spike rows against it.
// Optional macro PPE_ACCUM_EN adds a multi-row accumulation buffer and the ACCUM state.
module ppe_conv_sync #(
  parameter int MY_ADDR  = 5,
  parameter int ADDR_W   = 4,
  parameter int FILTER_W = 5,
  parameter int WEIGHT_W = 8,
  parameter int INPUT_W  = 25,
  parameter int PSUM_W   = 16,
  localparam int PKT_W   = ADDR_W + 2 + INPUT_W,
  localparam int OUT_N   = INPUT_W - FILTER_W + 1,
  localparam int IDX_W   = $clog2(OUT_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PKT_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] out_psum,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              weights_loaded
);

  localparam int WPP    = INPUT_W / WEIGHT_W;
  localparam int WCNT_W = $clog2(FILTER_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_N - 1);

`ifdef PPE_ACCUM_EN
  typedef enum logic [1:0] {IDLE, EMIT, ACCUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

  state_t state_q, state_d;

  logic [WEIGHT_W-1:0] weight [FILTER_W];
  logic [WCNT_W-1:0]   wcnt;
  logic [INPUT_W-1:0]  spike_q;
  logic [PSUM_W-1:0]   psum;

  logic [ADDR_W-1:0]   pkt_addr;
  logic                pkt_op;
  logic                addr_hit;
  logic                take;
  logic                out_hs;
  logic                idx_end;

  assign pkt_addr = in_data[PKT_W-1 -: ADDR_W];
  assign pkt_op   = in_data[INPUT_W+1];
  assign addr_hit = (pkt_addr == ADDR_W'(MY_ADDR));
  assign take     = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign idx_end  = (out_idx == LAST_IDX);
  assign out_last = out_valid && idx_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid && addr_hit && pkt_op) begin
`ifdef PPE_ACCUM_EN
          state_d = in_data[INPUT_W] ? EMIT : ACCUM;
`else
          state_d = EMIT;
`endif
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && idx_end) state_d = IDLE;
      end
`ifdef PPE_ACCUM_EN
      ACCUM: begin
        if (idx_end) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // psum(out_idx): taps see the spike row shifted down by the current position
  always_comb begin
    logic [INPUT_W-1:0] shifted;
    shifted = spike_q >> out_idx;
    psum    = '0;
    for (int unsigned k = 0; k < FILTER_W; k++) begin
      if (shifted[k]) psum = psum + PSUM_W'(weight[k]);
    end
  end

  // Weight slot placement: tap k takes payload slot (k - wcnt) when that slot exists
  logic                wr_en  [FILTER_W];
  logic [WEIGHT_W-1:0] wr_val [FILTER_W];
  logic [WCNT_W-1:0]   wcnt_d;
  logic                row_full;

  always_comb begin
    int unsigned base;
    int unsigned nxt;
    base = int'(wcnt);
    nxt  = (FILTER_W - base < WPP) ? FILTER_W : base + WPP;
    for (int unsigned k = 0; k < FILTER_W; k++) begin
      wr_en[k]  = 1'b0;
      wr_val[k] = weight[k];
      if (k >= base && (k - base) < WPP) begin
        wr_en[k]  = 1'b1;
        wr_val[k] = in_data[(k - base) * WEIGHT_W +: WEIGHT_W];
      end
    end
    row_full = (nxt >= FILTER_W);
    wcnt_d   = row_full ? '0 : WCNT_W'(nxt);
  end

`ifdef PPE_ACCUM_EN
  logic [PSUM_W-1:0] acc_buf [OUT_N];
  assign out_psum = acc_buf[out_idx] + psum;
`else
  assign out_psum = psum;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < FILTER_W; k++) weight[k] <= '0;
      wcnt           <= '0;
      weights_loaded <= 1'b0;
      spike_q        <= '0;
      out_idx        <= '0;
`ifdef PPE_ACCUM_EN
      for (int unsigned j = 0; j < OUT_N; j++) acc_buf[j] <= '0;
`endif
    end else begin
      if (take && addr_hit) begin
        if (!pkt_op) begin
          for (int unsigned k = 0; k < FILTER_W; k++) begin
            if (wr_en[k]) weight[k] <= wr_val[k];
          end
          wcnt <= wcnt_d;
          if (row_full) weights_loaded <= 1'b1;
        end else begin
          spike_q <= in_data[INPUT_W-1:0];
        end
      end
      if (out_hs) begin
        out_idx <= idx_end ? '0 : out_idx + 1'b1;
`ifdef PPE_ACCUM_EN
        acc_buf[out_idx] <= '0;
`endif
      end
`ifdef PPE_ACCUM_EN
      if (state_q == ACCUM) begin
        acc_buf[out_idx] <= acc_buf[out_idx] + psum;
        out_idx          <= idx_end ? '0 : out_idx + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ppe_conv_sync.sv
// Directed table-driven bench for ppe_conv_sync, plus hand sequences for mid-row reset,
// a narrow-psum instance and (with PPE_ACCUM_EN) row accumulation.
module tb_ppe_conv_sync;

  localparam int PKT_W = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid1, in_valid2, out_ready;
  logic [PKT_W-1:0] in_data;
  logic        in_ready1, in_ready2, ov1, ov2, last1, last2, ld1, ld2;
  logic [15:0] psum1;
  logic [3:0]  psum2;
  logic [4:0]  idx1, idx2;

  always #5 clk = ~clk;

  ppe_conv_sync u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_psum(psum1), .out_idx(idx1),
    .out_last(last1), .weights_loaded(ld1)
  );

  ppe_conv_sync #(.PSUM_W(4)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_psum(psum2), .out_idx(idx2),
    .out_last(last2), .weights_loaded(ld2)
  );

  logic        sel;
  logic        o_in_ready, o_valid, o_last, o_loaded;
  logic [15:0] o_psum;
  logic [4:0]  o_idx;
  assign o_in_ready = sel ? in_ready2 : in_ready1;
  assign o_valid    = sel ? ov2 : ov1;
  assign o_last     = sel ? last2 : last1;
  assign o_loaded   = sel ? ld2 : ld1;
  assign o_psum     = sel ? {12'h000, psum2} : psum1;
  assign o_idx      = sel ? idx2 : idx1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]        addr;
    logic              op;
    logic              last;
    logic [24:0]       payload;
    logic              stall;
    logic              exp_loaded;
    logic [4:0]        n_out;
    logic [21*16-1:0]  exp_ps;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] a, input logic op, input logic lst,
                              input logic [24:0] pl, input logic st, input logic ld,
                              input logic [4:0] n, input logic [15:0] p0, input logic [15:0] p1,
                              input logic [15:0] p2, input logic [15:0] p3, input logic [15:0] p4,
                              input logic [15:0] rest);
    vec_t v;
    logic [15:0] p [5];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3; p[4] = p4;
    v.addr = a; v.op = op; v.last = lst; v.payload = pl; v.stall = st;
    v.exp_loaded = ld; v.n_out = n;
    for (int j = 0; j < 21; j++) v.exp_ps[j*16 +: 16] = (j < 5) ? p[j] : rest;
    return v;
  endfunction

  task automatic set_valid(input logic b);
    if (sel) in_valid2 = b;
    else     in_valid1 = b;
  endtask

  task automatic send(input vec_t v);
    int w = 0;
    @(negedge clk);
    while (!o_in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready", o_in_ready, 1);
    in_data = {v.addr, v.op, v.last, v.payload};
    set_valid(1'b1);
    @(posedge clk);
    #1;
    set_valid(1'b0);
  endtask

  task automatic apply(input vec_t v);
    int cnt = 0;
    int cyc = 0;
    logic ph = 1'b0;
    send(v);
    @(negedge clk);
    chk("latency", o_valid, (v.n_out != 0));
    if (v.n_out == 0) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_output", o_valid, 0);
      end
    end else begin
      while (cnt < v.n_out && cyc < 400) begin
        out_ready = v.stall ? ph : 1'b1;
        ph = ~ph;
        if (o_valid) begin
          chk("out_idx", o_idx, cnt);
          chk("out_psum", o_psum, v.exp_ps[cnt*16 +: 16]);
          chk("out_last", o_last, (cnt == 20));
          if (out_ready) cnt++;
        end
        @(negedge clk);
        cyc++;
      end
      out_ready = 1'b1;
      chk("out_count", cnt, v.n_out);
      chk("row_done", o_valid, 0);
    end
    chk("weights_loaded", o_loaded, v.exp_loaded);
  endtask

  localparam logic [24:0] ONES = 25'h1FF_FFFF;
  vec_t vecs [7];

  initial begin
    vecs[0] = mk(4'd5, 1'b0, 1'b1, {1'b0, 8'd3, 8'd2, 8'd1}, 1'b0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mk(4'd5, 1'b0, 1'b1, {1'b0, 8'd9, 8'd5, 8'd4}, 1'b0, 1'b1, 5'd0, 0, 0, 0, 0, 0, 0);
    vecs[2] = mk(4'd5, 1'b1, 1'b1, 25'h10, 1'b0, 1'b1, 5'd21, 5, 4, 3, 2, 1, 0);
    vecs[3] = mk(4'd3, 1'b0, 1'b1, {1'b0, 8'd7, 8'd7, 8'd7}, 1'b0, 1'b1, 5'd0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(4'd3, 1'b1, 1'b1, ONES, 1'b0, 1'b1, 5'd0, 0, 0, 0, 0, 0, 0);
    vecs[5] = mk(4'd5, 1'b1, 1'b1, ONES, 1'b1, 1'b1, 5'd21, 15, 15, 15, 15, 15, 15);
    vecs[6] = mk(4'd5, 1'b1, 1'b1, 25'h5, 1'b0, 1'b1, 5'd21, 4, 2, 1, 0, 0, 0);

    sel = 1'b0; reset = 1'b1; in_valid1 = 1'b0; in_valid2 = 1'b0;
    in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_out_valid", o_valid, 0);
    chk("rst_out_psum", o_psum, 0);
    chk("rst_out_idx", o_idx, 0);
    chk("rst_out_last", o_last, 0);
    chk("rst_loaded", o_loaded, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) apply(vecs[i]);

    begin : mid_row_reset
      int w = 0;
      send(mk(4'd5, 1'b1, 1'b1, ONES, 1'b0, 1'b1, 5'd21, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      while (o_idx != 5'd7 && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("reach_idx7", o_idx, 7);
      reset = 1'b1;
      #1;
      chk("midrst_out_valid", o_valid, 0);
      chk("midrst_loaded", o_loaded, 0);
      chk("midrst_in_ready", o_in_ready, 0);
      chk("midrst_out_idx", o_idx, 0);
      @(negedge clk);
      reset = 1'b0;
      apply(mk(4'd5, 1'b1, 1'b1, ONES, 1'b0, 1'b0, 5'd21, 0, 0, 0, 0, 0, 0));
    end

    sel = 1'b1;
    apply(mk(4'd5, 1'b0, 1'b1, {1'b0, 8'd8, 8'd8, 8'd8}, 1'b0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0));
    apply(mk(4'd5, 1'b0, 1'b1, {1'b0, 8'd0, 8'd8, 8'd8}, 1'b0, 1'b1, 5'd0, 0, 0, 0, 0, 0, 0));
    apply(mk(4'd5, 1'b1, 1'b1, ONES, 1'b0, 1'b1, 5'd21, 8, 8, 8, 8, 8, 8));
    sel = 1'b0;

`ifdef PPE_ACCUM_EN
    apply(mk(4'd5, 1'b0, 1'b1, {1'b0, 8'd3, 8'd2, 8'd1}, 1'b0, 1'b0, 5'd0, 0, 0, 0, 0, 0, 0));
    apply(mk(4'd5, 1'b0, 1'b1, {1'b0, 8'd0, 8'd5, 8'd4}, 1'b0, 1'b1, 5'd0, 0, 0, 0, 0, 0, 0));
    apply(mk(4'd5, 1'b1, 1'b0, ONES, 1'b0, 1'b1, 5'd0, 0, 0, 0, 0, 0, 0));
    apply(mk(4'd5, 1'b1, 1'b1, ONES, 1'b0, 1'b1, 5'd21, 30, 30, 30, 30, 30, 30));
    apply(mk(4'd5, 1'b1, 1'b1, ONES, 1'b0, 1'b1, 5'd21, 15, 15, 15, 15, 15, 15));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
